ctrl_blk_pkt: RTL and testbench

CTRL_BLK_PKT -- requirements
Module: ctrl_blk_pkt

---
 rtl/ctrl_blk_pkg.sv | 23 ++
 rtl/ctrl_blk_pkt_if.sv | 35 +++
 rtl/ctrl_blk_pkt_ser2byte.sv | 59 +++++
 rtl/ctrl_blk_pkt.sv | 146 ++++++++++++++
 tb/tb_ctrl_blk_pkt.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_blk_pkg.sv
// ctrl_blk_pkg
//   Shared types and default constants for the ctrl_blk_pkt packet
//   receiver: packet-type and FSM-state enumerations plus the default
//   8-bit header codes.
//   No ports (package).
package ctrl_blk_pkg;

  typedef enum logic [1:0] {
    PKT_TEMP    = 2'd0,
    PKT_CHECK   = 2'd1,
    PKT_UNKNOWN = 2'd2
  } pkt_type_t;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHKSUM  = 2'd2
  } fsm_state_t;

  localparam logic [7:0] HDR_TEMP_DEF  = 8'hA5;
  localparam logic [7:0] HDR_CHECK_DEF = 8'hC3;

endpackage

// File: rtl/ctrl_blk_pkt_if.sv
// ctrl_blk_pkt_if
//   Bundles the serial input, FIFO handshake and packet status signals of
//   ctrl_blk_pkt.
//   master : the packet receiver (consumes serial_data/data_ena/fifo_full,
//            drives byte_out, byte_assembled, wr_fifo, pkt_type, pkt_done,
//            overflow, pkt_err)
//   slave  : the surrounding environment (opposite directions)
interface ctrl_blk_pkt_if
  import ctrl_blk_pkg::*;
#(
  parameter int BYTE_W = 8
);
  logic              serial_data;
  logic              data_ena;
  logic              fifo_full;
  logic [BYTE_W-1:0] byte_out;
  logic              byte_assembled;
  logic              wr_fifo;
  pkt_type_t         pkt_type;
  logic              pkt_done;
  logic              overflow;
  logic              pkt_err;

  modport master (
    input  serial_data, data_ena, fifo_full,
    output byte_out, byte_assembled, wr_fifo, pkt_type, pkt_done,
           overflow, pkt_err
  );

  modport slave (
    output serial_data, data_ena, fifo_full,
    input  byte_out, byte_assembled, wr_fifo, pkt_type, pkt_done,
           overflow, pkt_err
  );
endinterface

// File: rtl/ctrl_blk_pkt_ser2byte.sv
// ser2byte
//   Serial-to-byte assembler. Shifts serial_data in MSB first on every
//   cycle with data_ena high; every BYTE_W accepted bits the full byte is
//   loaded into byte_out and byte_assembled pulses for one cycle.
//   Ports:
//     clk_50         in   clock, rising edge
//     reset          in   synchronous active-high reset
//     serial_data    in   serial bit
//     data_ena       in   serial_data valid this cycle
//     byte_out       out  last assembled byte, held between pulses
//     byte_assembled out  one-cycle pulse, byte_out newly valid
module ser2byte #(
  parameter int BYTE_W = 8
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              serial_data,
  input  logic              data_ena,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_assembled
);
  localparam int CNT_W = $clog2(BYTE_W);

  logic [BYTE_W-1:0] shift_p0;
  logic [CNT_W-1:0]  bit_cnt_p0;
  logic [BYTE_W-1:0] shift_nxt;
  logic [BYTE_W-1:0] byte_p1;
  logic              vld_p1;

  assign shift_nxt = {shift_p0[BYTE_W-2:0], serial_data};

  // Stage p0: bit accumulation; the edge taking the last bit also
  // captures the completed byte (shift_nxt) into stage p1.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      shift_p0   <= '0;
      bit_cnt_p0 <= '0;
      byte_p1    <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (data_ena) begin
        shift_p0 <= shift_nxt;
        if (bit_cnt_p0 == CNT_W'(BYTE_W - 1)) begin
          bit_cnt_p0 <= '0;
          byte_p1    <= shift_nxt;
          vld_p1     <= 1'b1;
        end else begin
          bit_cnt_p0 <= bit_cnt_p0 + CNT_W'(1);
        end
      end
    end
  end

  // Stage p1: registered byte and its one-cycle valid.
  assign byte_out       = byte_p1;
  assign byte_assembled = vld_p1;

endmodule

// File: rtl/ctrl_blk_pkt.sv
// ctrl_blk_pkt
//   Serial packet receiver. Assembles bytes from a serial stream, hunts
//   for a temperature or check header, forwards temperature payload bytes
//   to a downstream FIFO and consumes check payload bytes silently.
//   Optional feature macro: CTRL_BLK_PKT_CHKSUM_EN -- adds an XOR checksum
//   byte after each payload, compared against the accumulated payload;
//   pkt_err pulses on mismatch. Without it pkt_err is tied low.
//   Ports:
//     clk_50  in   sole clock, rising edge
//     reset   in   synchronous active-high reset
//     bus     ctrl_blk_pkt_if.master: serial_data, data_ena, fifo_full in;
//             byte_out, byte_assembled, wr_fifo, pkt_type, pkt_done,
//             overflow (sticky), pkt_err out
module ctrl_blk_pkt
  import ctrl_blk_pkg::*;
#(
  parameter int                BYTE_W        = 8,
  parameter int                PAYLOAD_BYTES = 4,
  parameter logic [BYTE_W-1:0] HDR_TEMP      = BYTE_W'(HDR_TEMP_DEF),
  parameter logic [BYTE_W-1:0] HDR_CHECK     = BYTE_W'(HDR_CHECK_DEF)
) (
  input  logic           clk_50,
  input  logic           reset,
  ctrl_blk_pkt_if.master bus
);
  localparam int CNT_W = 8;

  logic [BYTE_W-1:0] byte_w;
  logic              ba_w;

  fsm_state_t        state_r, state_nxt;
  pkt_type_t         type_r, type_nxt;
  logic [CNT_W-1:0]  pay_cnt_r, pay_cnt_nxt;
  logic              ovf_r, ovf_nxt;
  logic              done_w;
  logic              wr_w;
  logic              last_pay;
`ifdef CTRL_BLK_PKT_CHKSUM_EN
  logic [BYTE_W-1:0] acc_r, acc_nxt;
  logic              err_w;
`endif

  ser2byte #(.BYTE_W(BYTE_W)) u_ser2byte (
    .clk_50         (clk_50),
    .reset          (reset),
    .serial_data    (bus.serial_data),
    .data_ena       (bus.data_ena),
    .byte_out       (byte_w),
    .byte_assembled (ba_w)
  );

  assign last_pay = (pay_cnt_r == CNT_W'(PAYLOAD_BYTES - 1));

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_r   <= HUNT;
      type_r    <= PKT_UNKNOWN;
      pay_cnt_r <= '0;
      ovf_r     <= 1'b0;
`ifdef CTRL_BLK_PKT_CHKSUM_EN
      acc_r     <= '0;
`endif
    end else begin
      state_r   <= state_nxt;
      type_r    <= type_nxt;
      pay_cnt_r <= pay_cnt_nxt;
      ovf_r     <= ovf_nxt;
`ifdef CTRL_BLK_PKT_CHKSUM_EN
      acc_r     <= acc_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state_r;
    type_nxt    = type_r;
    pay_cnt_nxt = pay_cnt_r;
    ovf_nxt     = ovf_r;
    done_w      = 1'b0;
`ifdef CTRL_BLK_PKT_CHKSUM_EN
    acc_nxt     = acc_r;
    err_w       = 1'b0;
`endif
    // A blocked FIFO drops the byte but the payload still counts it.
    wr_w = ba_w && (state_r == PAYLOAD) && (type_r == PKT_TEMP) && !bus.fifo_full;
    if (ba_w) begin
      case (state_r)
        HUNT: begin
          pay_cnt_nxt = '0;
          if (byte_w == HDR_TEMP) begin
            state_nxt = PAYLOAD;
            type_nxt  = PKT_TEMP;
          end else if (byte_w == HDR_CHECK) begin
            state_nxt = PAYLOAD;
            type_nxt  = PKT_CHECK;
          end else begin
            type_nxt  = PKT_UNKNOWN;
          end
        end
        PAYLOAD: begin
          pay_cnt_nxt = pay_cnt_r + CNT_W'(1);
          if (type_r == PKT_TEMP && bus.fifo_full) ovf_nxt = 1'b1;
`ifdef CTRL_BLK_PKT_CHKSUM_EN
          acc_nxt = acc_r ^ byte_w;
`endif
          if (last_pay) begin
            pay_cnt_nxt = '0;
`ifdef CTRL_BLK_PKT_CHKSUM_EN
            state_nxt = CHKSUM;
`else
            state_nxt = HUNT;
            type_nxt  = PKT_UNKNOWN;
            done_w    = 1'b1;
`endif
          end
        end
`ifdef CTRL_BLK_PKT_CHKSUM_EN
        CHKSUM: begin
          done_w    = 1'b1;
          err_w     = (byte_w != acc_r);
          acc_nxt   = '0;
          state_nxt = HUNT;
          type_nxt  = PKT_UNKNOWN;
        end
`endif
        default: begin
          state_nxt = HUNT;
          type_nxt  = PKT_UNKNOWN;
        end
      endcase
    end
  end

  assign bus.byte_out       = byte_w;
  assign bus.byte_assembled = ba_w;
  assign bus.wr_fifo        = wr_w;
  assign bus.pkt_type       = type_r;
  assign bus.pkt_done       = done_w;
  assign bus.overflow       = ovf_r;
`ifdef CTRL_BLK_PKT_CHKSUM_EN
  assign bus.pkt_err        = err_w;
`else
  assign bus.pkt_err        = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_blk_pkt.sv
// tb_ctrl_blk_pkt
//   Scoreboard bench for ctrl_blk_pkt. Each byte stream is parsed by a
//   stream-level reference model that queues the expected FIFO writes and
//   packet completions; a monitor on the falling edge pops and compares
//   whenever the DUT writes or completes a packet.
module tb_ctrl_blk_pkt;
  import ctrl_blk_pkg::*;

  localparam int         BYTE_W        = 8;
  localparam int         PAYLOAD_BYTES = 4;
  localparam logic [7:0] HT            = 8'hA5;
  localparam logic [7:0] HC            = 8'hC3;

  typedef struct {
    pkt_type_t t;
    logic      err;
  } done_t;

  logic clk_50 = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_50 = ~clk_50;

  ctrl_blk_pkt_if #(.BYTE_W(BYTE_W)) bus ();

  ctrl_blk_pkt #(
    .BYTE_W        (BYTE_W),
    .PAYLOAD_BYTES (PAYLOAD_BYTES),
    .HDR_TEMP      (HT),
    .HDR_CHECK     (HC)
  ) dut (
    .clk_50 (clk_50),
    .reset  (reset),
    .bus    (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         ba_cnt   = 0;
  bit         exp_ovf  = 1'b0;
  bit         done_prev = 1'b0;
  logic [7:0] exp_wr[$];
  done_t      exp_done[$];
  logic [7:0] stim_b[$];
  bit         stim_ff[$];

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Stream-level reference: skip to a header, take the following payload
  // (and checksum) bytes as one packet.
  function automatic void model_stream();
    int i;
    int n;
    i = 0;
    n = stim_b.size();
    while (i < n) begin
      logic [7:0] h;
      logic [7:0] x;
      int         last;
      done_t      d;
      h = stim_b[i];
      i++;
      if (h == HT || h == HC) begin
        x    = 8'h00;
        last = i + PAYLOAD_BYTES;
`ifdef CTRL_BLK_PKT_CHKSUM_EN
        last = last + 1;
`endif
        if (last > n) break;
        for (int k = 0; k < PAYLOAD_BYTES; k++) begin
          x = x ^ stim_b[i+k];
          if (h == HT) begin
            if (stim_ff[i+k]) exp_ovf = 1'b1;
            else exp_wr.push_back(stim_b[i+k]);
          end
        end
        d.t   = (h == HT) ? PKT_TEMP : PKT_CHECK;
        d.err = 1'b0;
`ifdef CTRL_BLK_PKT_CHKSUM_EN
        d.err = (stim_b[i+PAYLOAD_BYTES] != x);
`endif
        exp_done.push_back(d);
        i = last;
      end
    end
  endfunction

  // Monitor: compares at the falling edge, away from the active edge.
  always @(negedge clk_50) begin
    if (!reset) begin
      if (done_prev)
        chk(bus.pkt_type == PKT_UNKNOWN, "type_after_done", int'(bus.pkt_type), int'(PKT_UNKNOWN));
      if (bus.byte_assembled) ba_cnt++;
      if (bus.wr_fifo) begin
        chk(bus.pkt_type == PKT_TEMP, "wr_type", int'(bus.pkt_type), int'(PKT_TEMP));
        if (exp_wr.size() == 0) begin
          chk(1'b0, "unexpected_wr", int'(bus.byte_out), 0);
        end else begin
          logic [7:0] e;
          e = exp_wr.pop_front();
          chk(bus.byte_out == e, "wr_byte", int'(bus.byte_out), int'(e));
        end
      end
      if (bus.pkt_done) begin
        if (exp_done.size() == 0) begin
          chk(1'b0, "unexpected_done", int'(bus.pkt_type), 0);
        end else begin
          done_t d;
          d = exp_done.pop_front();
          chk(bus.pkt_type == d.t, "done_type", int'(bus.pkt_type), int'(d.t));
          chk(bus.pkt_err == d.err, "done_err", int'(bus.pkt_err), int'(d.err));
        end
      end else if (bus.pkt_err) begin
        chk(1'b0, "err_without_done", 1, 0);
      end
      done_prev = bus.pkt_done;
    end else begin
      done_prev = 1'b0;
    end
  end

  task automatic do_reset();
    reset           = 1'b1;
    bus.data_ena    = 1'b0;
    bus.serial_data = 1'b0;
    bus.fifo_full   = 1'b0;
    repeat (2) begin @(posedge clk_50); #1; end
    reset = 1'b0;
    exp_wr.delete();
    exp_done.delete();
    stim_b.delete();
    stim_ff.delete();
    exp_ovf = 1'b0;
    ba_cnt  = 0;
    chk(bus.byte_out == 8'h00, "rst_byte_out", int'(bus.byte_out), 0);
    chk(bus.byte_assembled == 1'b0, "rst_byte_assembled", int'(bus.byte_assembled), 0);
    chk(bus.wr_fifo == 1'b0, "rst_wr_fifo", int'(bus.wr_fifo), 0);
    chk(bus.pkt_type == PKT_UNKNOWN, "rst_pkt_type", int'(bus.pkt_type), int'(PKT_UNKNOWN));
    chk(bus.pkt_done == 1'b0, "rst_pkt_done", int'(bus.pkt_done), 0);
    chk(bus.overflow == 1'b0, "rst_overflow", int'(bus.overflow), 0);
    chk(bus.pkt_err == 1'b0, "rst_pkt_err", int'(bus.pkt_err), 0);
  endtask

  // fifo_full changes together with a byte's last bit so it is stable
  // through that byte's byte_assembled cycle.
  task automatic send_byte(input logic [7:0] b, input bit ff, input bit gaps);
    for (int k = BYTE_W - 1; k >= 0; k--) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
          bus.data_ena    = 1'b0;
          bus.serial_data = 1'($urandom_range(0, 1));
          @(posedge clk_50); #1;
        end
      end
      bus.data_ena    = 1'b1;
      bus.serial_data = b[k];
      if (k == 0) bus.fifo_full = ff;
      @(posedge clk_50); #1;
    end
    bus.data_ena = 1'b0;
  endtask

  task automatic push_raw(input logic [7:0] b, input bit ff);
    stim_b.push_back(b);
    stim_ff.push_back(ff);
  endtask

  task automatic push_pkt(input logic [7:0] h, input logic [7:0] pl[4], input bit fm[4], input bit bad_ck);
    logic [7:0] ck;
    ck = 8'h00;
    push_raw(h, 1'b0);
    for (int k = 0; k < PAYLOAD_BYTES; k++) begin
      push_raw(pl[k], fm[k]);
      ck = ck ^ pl[k];
    end
`ifdef CTRL_BLK_PKT_CHKSUM_EN
    if (bad_ck) ck = ck ^ 8'($urandom_range(1, 255));
    push_raw(ck, 1'($urandom_range(0, 1)));
`else
    if (bad_ck) ck = 8'h00;
`endif
  endtask

  task automatic run_stream(input string name, input bit gaps);
    int nb;
    model_stream();
    nb = stim_b.size();
    for (int i = 0; i < nb; i++) send_byte(stim_b[i], stim_ff[i], gaps);
    repeat (4) begin @(posedge clk_50); #1; end
    chk(exp_wr.size() == 0, {name, "_missing_wr"}, exp_wr.size(), 0);
    chk(exp_done.size() == 0, {name, "_missing_done"}, exp_done.size(), 0);
    chk(ba_cnt == nb, {name, "_byte_assembled_count"}, ba_cnt, nb);
    chk(bus.overflow == exp_ovf, {name, "_overflow"}, int'(bus.overflow), int'(exp_ovf));
    stim_b.delete();
    stim_ff.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pl[4];
    bit         fm[4];
    logic [7:0] jb;

    bus.data_ena    = 1'b0;
    bus.serial_data = 1'b0;
    bus.fifo_full   = 1'b0;

    // Temperature packet, continuous stream.
    do_reset();
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    fm = '{1'b0, 1'b0, 1'b0, 1'b0};
    push_pkt(HT, pl, fm, 1'b0);
    run_stream("temp", 1'b0);

    // Check packet: consumed, never written.
    do_reset();
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_pkt(HC, pl, fm, 1'b0);
    run_stream("check", 1'b0);

    // Junk before header; payload equal to header is data.
    do_reset();
    push_raw(8'h7E, 1'b0);
    pl = '{8'hA5, 8'h00, 8'h00, 8'hA5};
    push_pkt(HT, pl, fm, 1'b0);
    run_stream("hdr_in_payload", 1'b0);

    // FIFO full on the 2nd payload byte; overflow must persist.
    do_reset();
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    fm = '{1'b0, 1'b1, 1'b0, 1'b0};
    push_pkt(HT, pl, fm, 1'b0);
    pl = '{8'h55, 8'h66, 8'h77, 8'h88};
    fm = '{1'b0, 1'b0, 1'b0, 1'b0};
    push_pkt(HT, pl, fm, 1'b0);
    run_stream("overflow", 1'b0);

    // Reset after 5 bits of a header discards the partial byte.
    do_reset();
    jb = HT;
    for (int k = 7; k >= 3; k--) begin
      bus.data_ena    = 1'b1;
      bus.serial_data = jb[k];
      @(posedge clk_50); #1;
    end
    do_reset();
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_pkt(HT, pl, fm, 1'b0);
    run_stream("reset_mid_byte", 1'b0);

`ifdef CTRL_BLK_PKT_CHKSUM_EN
    do_reset();
    push_raw(8'hA5, 1'b0); push_raw(8'h01, 1'b0); push_raw(8'h02, 1'b0);
    push_raw(8'h04, 1'b0); push_raw(8'h08, 1'b0); push_raw(8'h0F, 1'b0);
    run_stream("chk_good", 1'b0);
    do_reset();
    push_raw(8'hA5, 1'b0); push_raw(8'h01, 1'b0); push_raw(8'h02, 1'b0);
    push_raw(8'h04, 1'b0); push_raw(8'h08, 1'b0); push_raw(8'h0E, 1'b0);
    run_stream("chk_bad", 1'b0);
`endif

    // Randomized mixes of junk, temp and check packets with data_ena gaps.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int p = 0; p < 6; p++) begin
        int kind;
        kind = $urandom_range(0, 2);
        if (kind == 0) begin
          jb = 8'($urandom_range(0, 255));
          while (jb == HT || jb == HC) jb = 8'($urandom_range(0, 255));
          push_raw(jb, 1'($urandom_range(0, 1)));
        end else begin
          for (int k = 0; k < PAYLOAD_BYTES; k++) begin
            pl[k] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) pl[k] = HT;
            fm[k] = ($urandom_range(0, 4) == 0);
          end
          push_pkt((kind == 1) ? HT : HC, pl, fm, 1'($urandom_range(0, 1)));
        end
      end
      run_stream("random", 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
